// File: rtl/set_query_arbiter_if.sv
// Query, engine and response bundle around the set query arbiter.
// master is the arbiter side; slave is the requester/engine/consumer side.
interface set_query_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req;
    logic [24*N_REQ-1:0] req_central;
    logic [12*N_REQ-1:0] req_radius;
    logic [2*N_REQ-1:0]  req_mode;
    logic [N_REQ-1:0]    gnt;

    logic                eng_en;
    logic [23:0]         eng_central;
    logic [11:0]         eng_radius;
    logic [1:0]          eng_mode;
    logic                eng_busy;
    logic                eng_valid;
    logic [7:0]          eng_candidate;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [7:0]          rsp_candidate;
    logic                rsp_err;

    modport master (
        input  req, req_central, req_radius, req_mode,
        input  eng_busy, eng_valid, eng_candidate, rsp_ready,
        output gnt, eng_en, eng_central, eng_radius, eng_mode,
        output rsp_valid, rsp_id, rsp_candidate, rsp_err
    );

    modport slave (
        output req, req_central, req_radius, req_mode,
        output eng_busy, eng_valid, eng_candidate, rsp_ready,
        input  gnt, eng_en, eng_central, eng_radius, eng_mode,
        input  rsp_valid, rsp_id, rsp_candidate, rsp_err
    );
endinterface

// File: rtl/set_query_arbiter.sv
// Round-robin arbiter sharing one circle-set counting engine among N_REQ requesters.
// Optional engine watchdog: define SET_ARB_TIMEOUT_EN.
module set_query_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 128
) (
    input  logic                clk,
    input  logic                rst,
    set_query_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (ID_W < $clog2(N_REQ) || N_REQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("set_query_arbiter: illegal parameter set");
    end

    localparam logic [ID_W:0] N_IDX    = (ID_W+1)'(N_REQ);
    localparam logic [ID_W:0] LAST_IDX = (ID_W+1)'(N_REQ - 1);

    state_t            state, state_d;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              eng_en_q, eng_en_d;
    logic [23:0]       central_q, central_d;
    logic [11:0]       radius_q, radius_d;
    logic [1:0]        mode_q, mode_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [7:0]        cand_q, cand_d;

    logic [N_REQ-1:0]  rot;
    logic              found;
    logic [ID_W-1:0]   off;
    logic [ID_W:0]     sum;
    logic [ID_W:0]     wrap;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   nxt_ptr;
    logic [23:0]       sel_central;
    logic [11:0]       sel_radius;
    logic [1:0]        sel_mode;
    logic              unused_busy;

    assign unused_busy = bus.eng_busy;

    // Rotate so bit 0 is rr_ptr; the first set bit is the winner's offset.
    always_comb begin
        rot   = N_REQ'({bus.req, bus.req} >> rr_ptr);
        found = 1'b0;
        off   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = ID_W'(k);
            end
        end
        sum     = {1'b0, rr_ptr} + {1'b0, off};
        wrap    = sum - N_IDX;
        pick    = (sum >= N_IDX) ? wrap[ID_W-1:0] : sum[ID_W-1:0];
        nxt_ptr = ({1'b0, pick} == LAST_IDX) ? '0 : pick + ID_W'(1);
    end

    always_comb begin
        sel_central = '0;
        sel_radius  = '0;
        sel_mode    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick == ID_W'(k)) begin
                sel_central = bus.req_central[24*k +: 24];
                sel_radius  = bus.req_radius[12*k +: 12];
                sel_mode    = bus.req_mode[2*k +: 2];
            end
        end
    end

`ifdef SET_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        gnt_d       = '0;
        eng_en_d    = 1'b0;
        central_d   = central_q;
        radius_d    = radius_q;
        mode_d      = mode_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        cand_d      = cand_q;
`ifdef SET_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    gnt_d     = N_REQ'(1) << pick;
                    central_d = sel_central;
                    radius_d  = sel_radius;
                    mode_d    = sel_mode;
                    rsp_id_d  = pick;
                    rr_ptr_d  = nxt_ptr;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                eng_en_d = 1'b1;
                state_d  = WAIT;
`ifdef SET_ARB_TIMEOUT_EN
                cnt_d    = '0;
`endif
            end
            WAIT: begin
                if (bus.eng_valid) begin
                    cand_d      = bus.eng_candidate;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef SET_ARB_TIMEOUT_EN
                    err_d       = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    cand_d      = 8'hFF;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gnt_q       <= '0;
            eng_en_q    <= 1'b0;
            central_q   <= '0;
            radius_q    <= '0;
            mode_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            cand_q      <= '0;
`ifdef SET_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            gnt_q       <= gnt_d;
            eng_en_q    <= eng_en_d;
            central_q   <= central_d;
            radius_q    <= radius_d;
            mode_q      <= mode_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            cand_q      <= cand_d;
`ifdef SET_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.eng_en        = eng_en_q;
    assign bus.eng_central   = central_q;
    assign bus.eng_radius    = radius_q;
    assign bus.eng_mode      = mode_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_candidate = cand_q;
`ifdef SET_ARB_TIMEOUT_EN
    assign bus.rsp_err       = err_q;
`else
    assign bus.rsp_err       = 1'b0;
`endif
endmodule

// File: tb/tb_set_query_arbiter.sv
// Bench for set_query_arbiter: directed table, corner sequences, random scoreboard.
// Build with SET_ARB_TIMEOUT_EN to exercise the watchdog path.
module tb_set_query_arbiter;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int TO = 16;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    int   m_ptr;

    logic [23:0] qc [NR];
    logic [11:0] qr [NR];
    logic [1:0]  qm [NR];

    typedef struct {
        logic [3:0] req;
        int         id;
        logic [7:0] cand;
        int         hold;
    } vec_t;

    vec_t tv [8];

    set_query_arbiter_if #(.N_REQ(NR), .ID_W(IW)) bus ();

    set_query_arbiter #(
        .N_REQ(NR), .ID_W(IW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    endtask

    task automatic check_zero(input string p);
        check({p, "_gnt"}, 32'(bus.gnt), 0);
        check({p, "_eng_en"}, 32'(bus.eng_en), 0);
        check({p, "_eng_central"}, 32'(bus.eng_central), 0);
        check({p, "_eng_radius"}, 32'(bus.eng_radius), 0);
        check({p, "_eng_mode"}, 32'(bus.eng_mode), 0);
        check({p, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({p, "_rsp_id"}, 32'(bus.rsp_id), 0);
        check({p, "_rsp_cand"}, 32'(bus.rsp_candidate), 0);
        check({p, "_rsp_err"}, 32'(bus.rsp_err), 0);
    endtask

    task automatic set_q(input int i, input logic [23:0] c,
                         input logic [11:0] r, input logic [1:0] m);
        qc[i] = c;
        qr[i] = r;
        qm[i] = m;
        bus.req_central[24*i +: 24] = c;
        bus.req_radius[12*i +: 12]  = r;
        bus.req_mode[2*i +: 2]      = m;
    endtask

    function automatic logic [7:0] eng_f(input logic [23:0] c,
                                         input logic [11:0] r,
                                         input logic [1:0] m);
        return c[7:0] ^ c[15:8] ^ c[23:16] ^ r[7:0] ^ {4'b0, r[11:8]} ^ {m, 6'b0};
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < NR; k++)
            if (r[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    task automatic do_reset(input bit chk);
        rst = 1'b1;
        bus.req = '0;
        bus.eng_valid = 1'b0;
        bus.eng_candidate = '0;
        bus.rsp_ready = 1'b0;
        m_ptr = 0;
        repeat (2) tick();
        if (chk) check_zero("reset");
        rst = 1'b0;
        tick();
    endtask

    // One complete transaction from an idle arbiter.
    task automatic txn(input logic [3:0] reqm, input int id,
                       input logic [7:0] cand, input int hold);
        int n;
        n = 0;
        bus.req = reqm;
        do begin
            tick();
            n++;
        end while (bus.gnt == '0 && n < 20);
        check("gnt", 32'(bus.gnt), 32'd1 << id);
        check("req2gnt_lat", n, 1);
        bus.req = '0;
        bus.eng_valid = 1'b1;
        bus.eng_candidate = 8'hEE;
        tick();
        bus.eng_valid = 1'b0;
        check("eng_en", 32'(bus.eng_en), 1);
        check("gnt_pulse", 32'(bus.gnt), 0);
        check("eng_central", 32'(bus.eng_central), 32'(qc[id]));
        check("eng_radius", 32'(bus.eng_radius), 32'(qr[id]));
        check("eng_mode", 32'(bus.eng_mode), 32'(qm[id]));
        tick();
        check("eng_en_pulse", 32'(bus.eng_en), 0);
        repeat (2) tick();
        check("no_early_rsp", 32'(bus.rsp_valid), 0);
        bus.eng_valid = 1'b1;
        bus.eng_candidate = cand;
        tick();
        bus.eng_valid = 1'b0;
        bus.eng_candidate = '0;
        check("rsp_valid", 32'(bus.rsp_valid), 1);
        check("rsp_id", 32'(bus.rsp_id), id);
        check("rsp_cand", 32'(bus.rsp_candidate), 32'(cand));
        check("rsp_err", 32'(bus.rsp_err), 0);
        if (hold > 0) bus.req = 4'b1110;
        for (int k = 0; k < hold; k++) begin
            tick();
            check("bp_gnt", 32'(bus.gnt), 0);
            check("bp_valid", 32'(bus.rsp_valid), 1);
            check("bp_id", 32'(bus.rsp_id), id);
            check("bp_cand", 32'(bus.rsp_candidate), 32'(cand));
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.req = '0;
        check("rsp_drop", 32'(bus.rsp_valid), 0);
        check("hs_gnt", 32'(bus.gnt), 0);
    endtask

    // Random requesters, engine and consumer against a queue scoreboard.
    task automatic run_loop(input int ncyc, input bit hold_all, input bit rnd_rdy);
        int          sb_id[$];
        logic [7:0]  sb_c[$];
        int          glog[$];
        bit          outst, arb, hs;
        int          cd, e, n_hs;
        logic [7:0]  ecand;
        logic [3:0]  rs;
        logic [23:0] xc;
        logic [11:0] xr;
        logic [1:0]  xm;
        outst = 0; cd = -1; n_hs = 0; ecand = '0;
        xc = '0; xr = '0; xm = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (hold_all) bus.req = 4'hF;
            else begin
                for (int i = 0; i < NR; i++) begin
                    if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                        set_q(i, 24'($urandom), 12'($urandom), 2'($urandom));
                        bus.req[i] = 1'b1;
                    end else if (bus.req[i] && $urandom_range(0, 31) == 0)
                        bus.req[i] = 1'b0;
                end
            end
            if (cd == 0) begin
                bus.eng_valid = 1'b1;
                bus.eng_candidate = ecand;
                cd = -1;
            end else begin
                bus.eng_valid = 1'b0;
                if (cd > 0) cd--;
            end
            bus.eng_busy = (cd >= 0);
            bus.rsp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = bus.rsp_valid && bus.rsp_ready;
            if (hs) begin
                check("sb_nonempty", 32'(sb_id.size() > 0), 1);
                if (sb_id.size() > 0) begin
                    check("rnd_rsp_id", 32'(bus.rsp_id), sb_id[0]);
                    check("rnd_rsp_cand", 32'(bus.rsp_candidate), 32'(sb_c[0]));
                    check("rnd_rsp_err", 32'(bus.rsp_err), 0);
                    void'(sb_id.pop_front());
                    void'(sb_c.pop_front());
                end
                n_hs++;
            end
            rs  = bus.req;
            arb = !outst;
            tick();
            if (hs) outst = 0;
            e = arb ? rr_pick(rs, m_ptr) : -1;
            check("rnd_gnt", 32'(bus.gnt), (e >= 0) ? (32'd1 << e) : 32'd0);
            if (e >= 0) begin
                m_ptr = (e + 1) % NR;
                outst = 1;
                sb_id.push_back(e);
                sb_c.push_back(eng_f(qc[e], qr[e], qm[e]));
                glog.push_back(e);
                xc = qc[e]; xr = qr[e]; xm = qm[e];
                if (!hold_all) bus.req[e] = 1'b0;
            end
            if (bus.eng_en) begin
                check("rnd_eng_central", 32'(bus.eng_central), 32'(xc));
                check("rnd_eng_radius", 32'(bus.eng_radius), 32'(xr));
                check("rnd_eng_mode", 32'(bus.eng_mode), 32'(xm));
                ecand = eng_f(bus.eng_central, bus.eng_radius, bus.eng_mode);
                cd = $urandom_range(0, 4);
            end
        end
        bus.eng_valid = 1'b0;
        bus.eng_busy = 1'b0;
        bus.rsp_ready = 1'b0;
        check("progress", 32'(n_hs >= ncyc / 30), 1);
        if (hold_all) begin
            check("rr_count", 32'(glog.size() >= 5), 1);
            for (int k = 0; k < 5; k++)
                check("rr_order", (k < glog.size()) ? glog[k] : -1, k % NR);
        end
    endtask

    initial begin
        bit seen;
        pass_cnt = 0;
        total_cnt = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.req_central = '0;
        bus.req_radius = '0;
        bus.req_mode = '0;
        bus.eng_busy = 1'b0;
        bus.eng_valid = 1'b0;
        bus.eng_candidate = '0;
        bus.rsp_ready = 1'b0;
        set_q(0, 24'h440000, 12'h300, 2'd0);
        set_q(1, 24'h123456, 12'h0AB, 2'd1);
        set_q(2, 24'hABCDEF, 12'hFFF, 2'd2);
        set_q(3, 24'h00FF00, 12'h001, 2'd3);

        tv[0] = '{4'b0001, 0, 8'd29,  0};
        tv[1] = '{4'b0001, 0, 8'h5A, 10};
        tv[2] = '{4'b1010, 1, 8'h00,  0};
        tv[3] = '{4'b1001, 3, 8'hFF,  0};
        tv[4] = '{4'b0110, 1, 8'h33,  0};
        tv[5] = '{4'b0100, 2, 8'h7E,  0};
        tv[6] = '{4'b0011, 0, 8'h01,  0};
        tv[7] = '{4'b1000, 3, 8'hC3,  0};

        do_reset(1'b1);
        for (int t = 0; t < 8; t++)
            txn(tv[t].req, tv[t].id, tv[t].cand, tv[t].hold);

        // Reset mid-WAIT after a grant to 2 leaves rr_ptr at 3 unless cleared.
        do_reset(1'b0);
        bus.req = 4'b0100;
        tick();
        check("rw_gnt", 32'(bus.gnt), 32'b0100);
        bus.req = '0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        tick();
        rst = 1'b0;
        bus.eng_valid = 1'b1;
        bus.eng_candidate = 8'h44;
        tick();
        bus.eng_valid = 1'b0;
        seen = 0;
        repeat (5) begin
            tick();
            seen |= bus.rsp_valid;
        end
        check("rst_no_rsp", 32'(seen), 0);
        bus.req = 4'hF;
        tick();
        check("rst_ptr_gnt", 32'(bus.gnt), 32'b0001);
        bus.req = '0;

        do_reset(1'b0);
        bus.req = 4'b0001;
        tick();
        check("long_gnt", 32'(bus.gnt), 32'b0001);
        bus.req = '0;
        tick();
        check("long_eng_en", 32'(bus.eng_en), 1);
        seen = 0;
`ifdef SET_ARB_TIMEOUT_EN
        for (int k = 1; k < TO; k++) begin
            tick();
            seen |= bus.rsp_valid;
        end
        check("to_not_early", 32'(seen), 0);
        tick();
        check("to_valid", 32'(bus.rsp_valid), 1);
        check("to_cand", 32'(bus.rsp_candidate), 32'hFF);
        check("to_err", 32'(bus.rsp_err), 1);
        check("to_id", 32'(bus.rsp_id), 0);
        bus.eng_valid = 1'b1;
        bus.eng_candidate = 8'h07;
        tick();
        bus.eng_valid = 1'b0;
        check("to_late_cand", 32'(bus.rsp_candidate), 32'hFF);
        check("to_late_valid", 32'(bus.rsp_valid), 1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        tick();
        check("to_done", 32'(bus.rsp_valid), 0);
`else
        for (int k = 0; k < 40; k++) begin
            tick();
            seen |= bus.rsp_valid;
        end
        check("wait_forever", 32'(seen), 0);
        bus.eng_valid = 1'b1;
        bus.eng_candidate = 8'h12;
        tick();
        bus.eng_valid = 1'b0;
        check("wait_valid", 32'(bus.rsp_valid), 1);
        check("wait_cand", 32'(bus.rsp_candidate), 32'h12);
        check("wait_err", 32'(bus.rsp_err), 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("wait_done", 32'(bus.rsp_valid), 0);
`endif

        do_reset(1'b0);
        run_loop(60, 1'b1, 1'b0);
        do_reset(1'b0);
        run_loop(2000, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
